// File: rtl/dmem_dump_reader_pkg.sv
// Shared types and constants for the post-halt data-memory dump engine.
// Optional feature macro: DMEM_DUMP_CHECKSUM_EN adds a trailing checksum beat.
package dmem_dump_pkg;

    // Default geometry of the data-memory port
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    // Address tag of the checksum beat (all ones, truncated to the port width)
    localparam logic [31:0] CSUM_MARK_ADDR = '1;

`ifdef DMEM_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHOW  = 3'd2,
        ST_DONE  = 3'd3,
        ST_CSUM  = 3'd4
    } dump_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHOW  = 3'd2,
        ST_DONE  = 3'd3
    } dump_state_e;
`endif

endpackage

// File: rtl/dmem_dump_reader_if.sv
// Memory read port plus dump stream handshake of the dump engine.
// master = the engine, slave = memory/sink side.
interface dmem_dump_reader_if
    import dmem_dump_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_addr;

    modport master (
        output mem_sel, mem_address, mem_wren,
        output dump_valid, dump_data, dump_addr,
        input  mem_q, dump_ready
    );

    modport slave (
        input  mem_sel, mem_address, mem_wren,
        input  dump_valid, dump_data, dump_addr,
        output mem_q, dump_ready
    );
endinterface

// File: rtl/dmem_dump_reader_edge.sv
// Rising-edge detector for the datapath halt flag. ht_q clears on reset, so a
// halt that is already high when reset releases is seen as a rise.
module ht_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic ht,
    output logic rise
);
    logic ht_q;

    // Track the previous halt level
    always_ff @(posedge clk) begin
        if (rst) begin
            ht_q <= 1'b0;
        end else begin
            ht_q <= ht;
        end
    end

    assign rise = ht & ~ht_q;
endmodule

// File: rtl/dmem_dump_reader.sv
// Post-halt data-memory readback engine: on a halt rise it walks WORD_COUNT
// words from START_ADDR and streams {address, word} over valid/ready.
// Optional feature macro: DMEM_DUMP_CHECKSUM_EN appends a sum beat tagged
// with an all-ones address.
module dmem_dump_reader
    import dmem_dump_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int START_ADDR = 0,
    parameter int WORD_COUNT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic ht,
    dmem_dump_reader_if.master bus,
    output logic busy,
    output logic done
);
    // Counter is one bit wider so a full 2^ADDR_W sweep is representable
    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WORD_COUNT - 1);
    localparam logic [ADDR_W-1:0] START_L  = ADDR_W'(START_ADDR);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ht_rise;
`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    ht_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .ht   (ht),
        .rise (ht_rise)
    );

    // State, pointer and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= START_L;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DMEM_DUMP_CHECKSUM_EN
    // Running sum of dumped words
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // Next-state logic and port outputs
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
`ifdef DMEM_DUMP_CHECKSUM_EN
        sum_d           = sum_q;
`endif
        bus.mem_sel     = 1'b0;
        bus.mem_address = ptr_q;
        bus.mem_wren    = 1'b0;
        bus.dump_valid  = 1'b0;
        bus.dump_data   = '0;
        bus.dump_addr   = '0;
        busy            = 1'b0;
        done            = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Every trigger restarts the walk from the configured origin
                if (ht_rise) begin
                    state_d = ST_FETCH;
                    ptr_d   = START_L;
                    cnt_d   = '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end

            ST_FETCH: begin
                bus.mem_sel = 1'b1;
                busy        = 1'b1;
                state_d     = ST_SHOW;
            end

            ST_SHOW: begin
                // Address stays at ptr so the memory keeps q stable while stalled
                bus.mem_sel    = 1'b1;
                busy           = 1'b1;
                bus.dump_valid = 1'b1;
                bus.dump_data  = bus.mem_q;
                bus.dump_addr  = ptr_q;
                if (bus.dump_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    ptr_d = ptr_q + 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    sum_d = sum_q + bus.mem_q;
                    state_d = (cnt_q == LAST_CNT) ? ST_CSUM : ST_FETCH;
`else
                    state_d = (cnt_q == LAST_CNT) ? ST_DONE : ST_FETCH;
`endif
                end
            end

`ifdef DMEM_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                bus.mem_sel    = 1'b1;
                bus.dump_valid = 1'b1;
                bus.dump_data  = sum_q;
                bus.dump_addr  = CSUM_MARK_ADDR[ADDR_W-1:0];
                if (bus.dump_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                // Hold until halt drops so one halt yields exactly one dump
                done = 1'b1;
                if (!ht) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dmem_dump_reader.sv
// Self-checking bench for dmem_dump_reader: two instances (origin 0 and
// origin 254, four words each) share ht/ready; a scoreboard holds the
// expected beats of the instance under observation.
module tb_dmem_dump_reader;
    import dmem_dump_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int WC = 4;
`ifdef DMEM_DUMP_CHECKSUM_EN
    localparam int CS_EXTRA = 1;
`else
    localparam int CS_EXTRA = 0;
`endif

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    typedef struct {
        bit which;
        int stall_beat;
        int stall_len;
        int exp_edges;
    } scen_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ht = 1'b0;
    logic ready = 1'b1;
    logic sel = 1'b0;
    logic busy0, done0, busy1, done1;
    logic [DW-1:0] mem0 [256];
    logic [DW-1:0] mem1 [256];

    logic          cv, cdone, cbusy;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;

    beat_t sbq[$];
    int checks = 0;
    int errors = 0;

    dmem_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
    dmem_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

    dmem_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(0), .WORD_COUNT(WC)) dut0 (
        .clk(clk), .rst(rst), .ht(ht), .bus(if0.master), .busy(busy0), .done(done0)
    );

    dmem_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(254), .WORD_COUNT(WC)) dut1 (
        .clk(clk), .rst(rst), .ht(ht), .bus(if1.master), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    assign if0.dump_ready = ready;
    assign if1.dump_ready = ready;

    always @(posedge clk) begin
        if0.mem_q <= mem0[if0.mem_address];
        if1.mem_q <= mem1[if1.mem_address];
    end

    always_comb begin
        cv    = sel ? if1.dump_valid : if0.dump_valid;
        ca    = sel ? if1.dump_addr  : if0.dump_addr;
        cd    = sel ? if1.dump_data  : if0.dump_data;
        cdone = sel ? done1 : done0;
        cbusy = sel ? busy1 : busy0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_dump(input bit which);
        logic [AW-1:0] a;
        logic [DW-1:0] sum;
        beat_t b;
        sum = '0;
        for (int k = 0; k < WC; k++) begin
            a   = AW'((which ? 254 : 0) + k);
            b.a = a;
            b.d = which ? mem1[a] : mem0[a];
            sum = sum + b.d;
            sbq.push_back(b);
        end
`ifdef DMEM_DUMP_CHECKSUM_EN
        b.a = '1;
        b.d = sum;
        sbq.push_back(b);
`endif
    endtask

    task automatic run_dump(input bit which, input int stall_beat, input int stall_len,
                            input bit hold_ht, output int edges);
        int beat, stalled;
        bit finished;
        beat_t b;
        sel = which;
        push_dump(which);
        @(negedge clk);
        ht = 1'b1;
        edges = -1;
        beat = 0;
        stalled = 0;
        finished = 0;
        for (int i = 0; i < 200 && !finished; i++) begin
            @(negedge clk);
            if (!hold_ht) ht = 1'b0;
            if (cdone) begin
                finished = 1;
                edges = i;
            end else if (cv) begin
                if (beat == stall_beat && stalled < stall_len) begin
                    ready = 1'b0;
                    stalled++;
                    if (sbq.size() > 0) begin
                        check("stall_addr", 64'(ca), 64'(sbq[0].a));
                        check("stall_data", 64'(cd), 64'(sbq[0].d));
                    end
                end else begin
                    ready = 1'b1;
                    if (sbq.size() == 0) begin
                        check("extra_beat", 64'(1), 64'(0));
                    end else begin
                        b = sbq.pop_front();
                        check("beat_addr", 64'(ca), 64'(b.a));
                        check("beat_data", 64'(cd), 64'(b.d));
                    end
                    beat++;
                end
            end else begin
                ready = 1'b1;
            end
        end
        ready = 1'b1;
        if (!finished) check("done_timeout", 64'(0), 64'(1));
        check("busy_at_done", 64'(cbusy), 64'(0));
        check("beats_left", 64'(sbq.size()), 64'(0));
        sbq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        scen_t tbl [4];
        int edges;
        int vcount;
        bit got;

        tbl[0] = '{which: 1'b0, stall_beat: -1, stall_len: 0, exp_edges: 8};
        tbl[1] = '{which: 1'b0, stall_beat:  1, stall_len: 5, exp_edges: 13};
        tbl[2] = '{which: 1'b1, stall_beat: -1, stall_len: 0, exp_edges: 8};
        tbl[3] = '{which: 1'b0, stall_beat:  2, stall_len: 3, exp_edges: 11};

        for (int i = 0; i < 256; i++) begin
            mem0[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            mem1[i] = (32'(i) * 32'h0001_0203) ^ 32'h5A00_00FF;
        end
        mem0[0] = 32'h0000_000F;
        mem0[1] = 32'h0000_0008;
        mem0[2] = 32'h0000_000C;
        mem0[3] = 32'hDEAD_BEEF;
        mem1[254] = 32'h1111_1111;
        mem1[255] = 32'h2222_2222;
        mem1[0]   = 32'h3333_3333;
        mem1[1]   = 32'h4444_4444;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_mem_sel",   64'(if0.mem_sel),     64'(0));
        check("rst_mem_addr0", 64'(if0.mem_address), 64'(0));
        check("rst_mem_addr1", 64'(if1.mem_address), 64'(254));
        check("rst_mem_wren",  64'(if0.mem_wren),    64'(0));
        check("rst_valid",     64'(if0.dump_valid),  64'(0));
        check("rst_data",      64'(if0.dump_data),   64'(0));
        check("rst_addr",      64'(if0.dump_addr),   64'(0));
        check("rst_busy",      64'(busy0),           64'(0));
        check("rst_done",      64'(done0),           64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_valid", 64'(if0.dump_valid), 64'(0));

        // Table-driven dump scenarios
        for (int s = 0; s < 4; s++) begin
            run_dump(tbl[s].which, tbl[s].stall_beat, tbl[s].stall_len, 1'b0, edges);
            check($sformatf("edges_s%0d", s), 64'(edges), 64'(tbl[s].exp_edges + CS_EXTRA));
            check("done_level", 64'(cdone), 64'(1));
            check("wren_zero", 64'(if0.mem_wren), 64'(0));
        end

        // Halt held high after completion: no second dump
        @(negedge clk);
        run_dump(1'b0, -1, 0, 1'b1, edges);
        check("edges_hold", 64'(edges), 64'(8 + CS_EXTRA));
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if0.dump_valid) vcount++;
        end
        check("hold_no_valid", 64'(vcount), 64'(0));
        check("hold_done", 64'(done0), 64'(1));
        ht = 1'b0;
        @(negedge clk);
        check("rearm_done_low", 64'(done0), 64'(0));
        run_dump(1'b0, -1, 0, 1'b0, edges);
        check("edges_rearm", 64'(edges), 64'(8 + CS_EXTRA));

        // Reset during the second beat aborts the dump
        @(negedge clk);
        sel = 1'b0;
        push_dump(1'b0);
        @(negedge clk);
        ht = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            beat_t b;
            @(negedge clk);
            ht = 1'b0;
            if (if0.dump_valid) begin
                b = sbq.pop_front();
                check("abort_addr", 64'(if0.dump_addr), 64'(b.a));
                check("abort_data", 64'(if0.dump_data), 64'(b.d));
                if (b.a == 8'd1) begin
                    rst = 1'b1;
                    got = 1;
                end
            end
        end
        if (!got) check("abort_timeout", 64'(0), 64'(1));
        @(negedge clk);
        check("abort_valid", 64'(if0.dump_valid), 64'(0));
        check("abort_busy",  64'(busy0),          64'(0));
        check("abort_done",  64'(done0),          64'(0));
        rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        run_dump(1'b0, -1, 0, 1'b0, edges);
        check("edges_restart", 64'(edges), 64'(8 + CS_EXTRA));

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_dump_reader.md
# dmem_dump_reader

Post-halt data-memory readback engine. When the datapath raises `ht`, it takes the data-memory read port, walks a configured word range, and streams each word with its word address over a valid/ready handshake to a host or capture sink. It is the consumer of everything the datapath's store path wrote. It sits beside the datapath on the data-memory bus; a top-level mux selects the engine's address when `mem_sel` is high.

## Interface
- `ADDR_W`, 8, word-address width; matches the data-memory address port.
- `DATA_W`, 32, memory word width.
- `START_ADDR`, 0, first word address dumped.
- `WORD_COUNT`, 256, number of words dumped, 1..2^ADDR_W.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ht` in 1: halt flag from the datapath; its rising edge triggers a dump.
- `mem_sel` out 1: engine owns the data-memory port.
- `mem_address` out ADDR_W: word address to data memory.
- `mem_wren` out 1: constant 0; the engine never writes.
- `mem_q` in DATA_W: memory read data, valid one cycle after the address is presented.
- `dump_valid` out 1: output word valid.
- `dump_ready` in 1: sink accepts the word.
- `dump_data` out DATA_W: word being dumped.
- `dump_addr` out ADDR_W: word address of `dump_data`.
- `busy` out 1: dump in progress.
- `done` out 1: dump complete, held until re-arm.

## Operation
- States: IDLE, FETCH, SHOW, DONE. Reset forces IDLE, `ptr`=START_ADDR, `cnt`=0, `ht_q`=0.
- The rising-edge detector is `ht & ~ht_q`. If `ht` is already high when reset is released, that counts as a rise.
- IDLE: on a rise, go to FETCH.
- FETCH: present `mem_address`=`ptr`, then go to SHOW.
- SHOW:
  - `dump_valid`=1, `dump_data`=`mem_q`, `dump_addr`=`ptr`.
  - `mem_address` is held at `ptr`, so the memory re-registers the same address and `q` stays stable during a stall.
  - On `dump_valid & dump_ready`: increment `cnt`, `ptr`=`ptr`+1 modulo 2^ADDR_W (wraps from 255 to 0).
  - Then FETCH if `cnt`+1 < WORD_COUNT, else DONE.
- DONE: `done`=1. Return to IDLE when `ht` is low, which re-arms for the next halt.
- `busy`=1 in FETCH and SHOW. `mem_sel`=1 in FETCH, SHOW, and the checksum state.
- `dump_data`/`dump_addr` are don't-care when `dump_valid`=0. The sink must not depend on them.
- `ht` falling mid-dump is ignored; the dump completes.
- A new rise during a dump is ignored.
- `rst` mid-dump aborts immediately: `dump_valid` is 0 in the cycle after the reset edge, with no partial handshake.
- `dump_valid` never drops without a handshake except on `rst`.

## Timing
- `ht` rise sampled at edge N: FETCH in cycle N+1, and `dump_valid`=1 from cycle N+2.
- With `dump_ready` tied high there is one word every 2 cycles, so WORD_COUNT words take 2·WORD_COUNT cycles.
- `done` asserts the cycle after the last handshake.
- Reset values: `mem_sel`=0, `mem_address`=START_ADDR, `dump_valid`=0, `dump_data`=0, `dump_addr`=0, `busy`=0, `done`=0.

## Configuration
- Macro: `DMEM_DUMP_CHECKSUM_EN`.
- When defined:
  - The engine keeps a running sum of every dumped word, modulo 2^DATA_W, cleared on a trigger.
  - After the last data word it enters state CSUM and emits one extra beat with `dump_data`=sum and `dump_addr`=all ones, under the same handshake.
  - It then goes to DONE.
- When undefined: no CSUM state, no sum register, and the stream ends with the last data word.

## Structure
- Package `dmem_dump_pkg` holds:
  - the state enum;
  - the `ADDR_W`/`DATA_W` defaults;
  - the checksum-marker address constant (all ones).
- Sub-module `ht_edge_det` provides the registered `ht` rise pulse with its reset behaviour.
- All other logic is one FSM module.

## Test plan
- Memory words 0..3 preloaded with 0x0000000F, 0x00000008, 0x0000000C, 0xDEADBEEF; WORD_COUNT=4; `dump_ready`=1; pulse `ht` → beats (0,0xF), (1,0x8), (2,0xC), (3,0xDEADBEEF) 2 cycles apart. `done` is high the cycle after beat 3.
- Same setup, `dump_ready` low for 5 cycles during beat 1 → `dump_valid`, `dump_data`=0x8 and `dump_addr`=1 stay stable throughout. No beat is lost or duplicated.
- START_ADDR=254, WORD_COUNT=4 → `dump_addr` sequence 254, 255, 0, 1.
- `rst` asserted in the cycle of the second beat → `dump_valid`=0 and `busy`=0 next cycle. A new `ht` rise restarts from START_ADDR.
- `ht` held high after DONE → no second dump. Drop then raise `ht` → a second identical dump runs.
- With `DMEM_DUMP_CHECKSUM_EN` and the first-scenario data → a fifth beat with `dump_addr`=0xFF and `dump_data`=0xDEADBF12.
